// File: rtl/bus_port_fifo_if.sv
// Bus-port FIFO interface.
// Bundles the device-side and bus-side signals of one bus port.
// Modports:
//   slave  - the FIFO block itself (drives tx_full/tx_count/pndng/D_pop/dev_valid/dev_rdata/rx_count/err)
//   master - the device plus bus arbiter environment (drives dev_wr/dev_wdata/pop/push/D_push/dev_rd)
interface bus_port_fifo_if #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 16
);
  localparam int unsigned CW = $clog2(depth + 1);

  // TX side: device writes, bus pops
  logic               dev_wr;
  logic [pckg_sz-1:0] dev_wdata;
  logic               tx_full;
  logic [CW-1:0]      tx_count;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  // RX side: bus pushes, device reads
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               dev_valid;
  logic [pckg_sz-1:0] dev_rdata;
  logic               dev_rd;
  logic [CW-1:0]      rx_count;
  // sticky {rx_underflow, rx_overflow, tx_underflow, tx_overflow}
  logic [3:0]         err;

  modport slave (
    input  dev_wr, dev_wdata, pop, push, D_push, dev_rd,
    output tx_full, tx_count, pndng, D_pop, dev_valid, dev_rdata, rx_count, err
  );

  modport master (
    output dev_wr, dev_wdata, pop, push, D_push, dev_rd,
    input  tx_full, tx_count, pndng, D_pop, dev_valid, dev_rdata, rx_count, err
  );
endinterface

// File: rtl/bus_port_fifo.sv
// Per-port buffering stage between one device and one bus port.
// TX FIFO: device writes (dev_wr/dev_wdata), bus sees FWFT head (pndng/D_pop) and pops.
// RX FIFO: bus pushes (push/D_push), device sees FWFT head (dev_valid/dev_rdata) and reads.
// Ports: clk, reset (async active-low), bus (bus_port_fifo_if.slave).
// Every output comes from a flop; heads, flags and counts are computed from next state.

// Circular FWFT FIFO with registered head/flags and sticky over/underflow flags.
module bus_port_fifo_ring #(
  parameter  int unsigned width = 16,
  parameter  int unsigned depth = 16,
  localparam int unsigned AW    = $clog2(depth),
  localparam int unsigned CW    = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic             valid,
  output logic             full,
  output logic [width-1:0] head,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);
  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] head_q, head_d;
  logic             valid_q, valid_d, full_q, full_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             empty, at_cap, rd_ok, wr_ok;

  // Next-state: pointers, count, registered head and sticky errors
  always_comb begin
    empty    = (count_q == CW'(0));
    at_cap   = (count_q == CW'(depth));
    rd_ok    = rd && !empty;
    wr_ok    = wr && (!at_cap || rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != CW'(0));
    full_d  = (count_d == CW'(depth));
    // The word being written lands at the new head when it is the only entry left
    if (!valid_d)
      head_d = '0;
    else if (wr_ok && (wr_ptr_q == rd_ptr_d))
      head_d = wdata;
    else
      head_d = mem_q[rd_ptr_d];
    ovf_d = ovf_q | (wr && at_cap && !rd_ok);
    unf_d = unf_q | (rd && empty);
  end

  // Storage array, no reset needed: contents are qualified by count
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign valid = valid_q;
  assign full  = full_q;
  assign head  = head_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
endmodule

module bus_port_fifo #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 16
) (
  input logic              clk,
  input logic              reset,
  bus_port_fifo_if.slave   bus
);
  localparam int unsigned CW = $clog2(depth + 1);

  logic               tx_full, tx_pndng, tx_ovf, tx_unf;
  logic [CW-1:0]      tx_count;
  logic [pckg_sz-1:0] tx_head;
  logic               rx_full, rx_valid, rx_ovf, rx_unf;
  logic [CW-1:0]      rx_count;
  logic [pckg_sz-1:0] rx_head;

  // Device -> bus
  bus_port_fifo_ring #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk   (clk),
    .rst_n (reset),
    .wr    (bus.dev_wr),
    .wdata (bus.dev_wdata),
    .rd    (bus.pop),
    .valid (tx_pndng),
    .full  (tx_full),
    .head  (tx_head),
    .count (tx_count),
    .ovf   (tx_ovf),
    .unf   (tx_unf)
  );

  // Bus -> device; RX full is not exported
  bus_port_fifo_ring #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk   (clk),
    .rst_n (reset),
    .wr    (bus.push),
    .wdata (bus.D_push),
    .rd    (bus.dev_rd),
    .valid (rx_valid),
    .full  (rx_full),
    .head  (rx_head),
    .count (rx_count),
    .ovf   (rx_ovf),
    .unf   (rx_unf)
  );

  assign bus.tx_full   = tx_full;
  assign bus.tx_count  = tx_count;
  assign bus.pndng     = tx_pndng;
  assign bus.D_pop     = tx_head;
  assign bus.dev_valid = rx_valid & (rx_full | ~rx_full);
  assign bus.dev_rdata = rx_head;
  assign bus.rx_count  = rx_count;
  assign bus.err       = {rx_unf, rx_ovf, tx_unf, tx_ovf};
endmodule
